// File: rtl/pio_out_shift_reg.sv
// PIO output shift register: pulls words from the TX FIFO and hands
// 1..32 bits per OUT command to the execution unit, with autopull.
module pio_out_shift_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_pop,
  input  logic        out_req,
  input  logic [4:0]  out_bits,
  input  logic        pull_req,
  input  logic        pull_block,
  input  logic        shift_right,
  input  logic        autopull_en,
  input  logic [4:0]  pull_thresh,
  output logic        stall,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic [5:0]  osr_count
);

  typedef enum logic {READY, FETCH} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] osr;
  logic [5:0]  n;
  logic [5:0]  t;
  logic        need_pull;
  logic        do_out;
  logic [31:0] mask;
  logic [31:0] shr_data;
  logic [31:0] shl_data;
  logic [31:0] shr_osr;
  logic [31:0] shl_osr;
  logic [6:0]  cnt_sum;

  assign n = (out_bits == 5'd0) ? 6'd32 : {1'b0, out_bits};
  assign t = (pull_thresh == 5'd0) ? 6'd32 : {1'b0, pull_thresh};
  assign need_pull = autopull_en && (osr_count >= t);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= READY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      READY: begin
        if ((pull_req || (out_req && need_pull)) && !fifo_empty)
          state_nxt = FETCH;
      end
      FETCH: state_nxt = READY;
    endcase
  end

  // PULL has priority; an OUT behind it keeps stalling until it is served
  always_comb begin
    fifo_pop = 1'b0;
    stall    = 1'b0;
    do_out   = 1'b0;
    unique case (state)
      READY: begin
        if (pull_req) begin
          fifo_pop = !fifo_empty;
          stall    = !fifo_empty || pull_block;
        end else if (out_req) begin
          if (need_pull) begin
            fifo_pop = !fifo_empty;
            stall    = 1'b1;
          end else begin
            do_out = 1'b1;
          end
        end
      end
      FETCH: stall = !pull_req;
    endcase
    if (rst) fifo_pop = 1'b0;
  end

  assign mask     = (n == 6'd32) ? '1 : ((32'd1 << n[4:0]) - 32'd1);
  assign shr_data = osr & mask;
  assign shr_osr  = (n == 6'd32) ? 32'd0 : (osr >> n[4:0]);
  assign shl_data = osr >> (6'd32 - n);
  assign shl_osr  = (n == 6'd32) ? 32'd0 : (osr << n[4:0]);
  assign cnt_sum  = {1'b0, osr_count} + {1'b0, n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      osr       <= 32'd0;
      osr_count <= 6'd32;
      out_data  <= 32'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= do_out;
      if (state == FETCH) begin
        osr       <= fifo_data;
        osr_count <= 6'd0;
      end else if (do_out) begin
        out_data  <= shift_right ? shr_data : shl_data;
        osr       <= shift_right ? shr_osr : shl_osr;
        osr_count <= (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[5:0];
      end
    end
  end

endmodule

// File: tb/tb_pio_out_shift_reg.sv
// Bench for pio_out_shift_reg: FIFO model, per-cycle reference model
// and directed command sequences with hand-computed values.
module tb_pio_out_shift_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fifo_data = 32'd0;
  logic        fifo_empty = 1'b1;
  logic        fifo_pop;
  logic        out_req = 1'b0;
  logic [4:0]  out_bits = 5'd0;
  logic        pull_req = 1'b0;
  logic        pull_block = 1'b0;
  logic        shift_right = 1'b0;
  logic        autopull_en = 1'b0;
  logic [4:0]  pull_thresh = 5'd0;
  logic        stall;
  logic [31:0] out_data;
  logic        out_valid;
  logic [5:0]  osr_count;

  pio_out_shift_reg dut (
    .clk(clk), .rst(rst),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .out_req(out_req), .out_bits(out_bits),
    .pull_req(pull_req), .pull_block(pull_block),
    .shift_right(shift_right), .autopull_en(autopull_en),
    .pull_thresh(pull_thresh), .stall(stall),
    .out_data(out_data), .out_valid(out_valid), .osr_count(osr_count)
  );

  always #5 clk = ~clk;

  logic [31:0] fifo_q[$];
  logic        push_en = 1'b0;
  logic [31:0] push_w = 32'd0;
  logic        pop_s = 1'b0;

  logic [31:0] m_osr = 32'd0;
  int          m_cnt = 32;
  logic [31:0] m_outd = 32'd0;
  logic        m_outv = 1'b0;
  logic        m_fetch = 1'b0;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        tmo = 1'b0;
  logic        pin_en = 1'b0;
  string       pin_nm = "";
  logic [31:0] pin_a = 32'd0;
  logic [31:0] pin_e = 32'd0;

  // FIFO and reference model, advanced once per clock edge
  always @(posedge clk) begin
    automatic int n = (out_bits == 5'd0) ? 32 : int'(out_bits);
    automatic int t = (pull_thresh == 5'd0) ? 32 : int'(pull_thresh);
    automatic logic [63:0] w = {32'd0, m_osr};
    if (rst) begin
      m_osr <= 32'd0; m_cnt <= 32; m_outd <= 32'd0;
      m_outv <= 1'b0; m_fetch <= 1'b0;
    end else begin
      m_outv <= 1'b0;
      if (m_fetch) begin
        m_osr <= fifo_data; m_cnt <= 0; m_fetch <= 1'b0;
      end else if (pull_req) begin
        if (!fifo_empty) m_fetch <= 1'b1;
      end else if (out_req) begin
        if (autopull_en && m_cnt >= t) begin
          if (!fifo_empty) m_fetch <= 1'b1;
        end else begin
          if (shift_right) begin
            m_outd <= 32'(w % (64'd1 << n));
            m_osr  <= 32'(w >> n);
          end else begin
            w = w << n;
            m_outd <= w[63:32];
            m_osr  <= w[31:0];
          end
          m_cnt  <= (m_cnt + n > 32) ? 32 : m_cnt + n;
          m_outv <= 1'b1;
        end
      end
    end
    if (pop_s && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    if (push_en) fifo_q.push_back(push_w);
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    automatic int t = (pull_thresh == 5'd0) ? 32 : int'(pull_thresh);
    automatic logic e_pop = 1'b0;
    automatic logic e_stall = 1'b0;
    pop_s <= fifo_pop;
    if (rst) begin
      chk("pop_in_rst", 32'(fifo_pop), 32'd0);
    end else begin
      if (m_fetch) begin
        e_stall = !pull_req;
      end else if (pull_req) begin
        e_pop   = !fifo_empty;
        e_stall = !fifo_empty || pull_block;
      end else if (out_req && autopull_en && m_cnt >= t) begin
        e_pop   = !fifo_empty;
        e_stall = 1'b1;
      end
      chk("fifo_pop", 32'(fifo_pop), 32'(e_pop));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("osr_count", 32'(osr_count), 32'(m_cnt));
      chk("out_valid", 32'(out_valid), 32'(m_outv));
      chk("out_data", out_data, m_outd);
    end
    chk("timeout", 32'(tmo), 32'd0);
    if (pin_en) chk(pin_nm, pin_a, pin_e);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic pin(input string nm, input logic [31:0] a, input logic [31:0] e);
    pin_nm = nm; pin_a = a; pin_e = e; pin_en = 1'b1;
    @(negedge clk); #1;
    pin_en = 1'b0;
  endtask

  task automatic push(input logic [31:0] wd);
    push_w = wd; push_en = 1'b1;
    cyc();
    push_en = 1'b0;
  endtask

  task automatic wait_done(output int k, output logic p0);
    k = 0;
    #1;
    p0 = fifo_pop;
    while (stall && k < 50) begin
      cyc(); k++;
    end
    if (k >= 50) tmo = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_pull(input logic blk, output int k, output logic p0);
    pull_block = blk; pull_req = 1'b1;
    wait_done(k, p0);
    pull_req = 1'b0;
  endtask

  task automatic do_out(input logic [4:0] b, input logic r, output int k);
    logic p0;
    out_bits = b; shift_right = r; out_req = 1'b1;
    wait_done(k, p0);
    out_req = 1'b0;
  endtask

  initial begin
    int k;
    logic p;
    logic v;
    logic [31:0] d;
    logic [5:0] c;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    pin("rst_count", 32'(osr_count), 32'd32);
    pin("rst_data", out_data, 32'd0);
    pin("rst_valid", 32'(out_valid), 32'd0);
    pin("rst_stall", 32'(stall), 32'd0);

    push(32'hDEADBEEF);
    do_pull(1'b1, k, p);
    c = osr_count;
    pin("pull_pop", 32'(p), 32'd1);
    pin("pull_stalls", 32'(k), 32'd1);
    pin("pull_count", 32'(c), 32'd0);

    do_out(5'd8, 1'b1, k);
    v = out_valid; d = out_data; c = osr_count;
    pin("r8a_valid", 32'(v), 32'd1);
    pin("r8a_data", d, 32'h000000EF);
    pin("r8a_model", m_outd, 32'h000000EF);
    pin("r8a_count", 32'(c), 32'd8);
    do_out(5'd8, 1'b1, k);
    d = out_data; c = osr_count;
    pin("r8b_data", d, 32'h000000BE);
    pin("r8b_count", 32'(c), 32'd16);

    push(32'h12345678);
    do_pull(1'b1, k, p);
    do_out(5'd0, 1'b0, k);
    d = out_data; c = osr_count;
    pin("l32_data", d, 32'h12345678);
    pin("l32_count", 32'(c), 32'd32);
    pin("l32_osr", m_osr, 32'd0);

    autopull_en = 1'b1; pull_thresh = 5'd0;
    push(32'hA5A5A5A5);
    do_out(5'd4, 1'b1, k);
    d = out_data; c = osr_count;
    pin("ap_stalls", 32'(k), 32'd2);
    pin("ap_data", d, 32'h5);
    pin("ap_count", 32'(c), 32'd4);
    autopull_en = 1'b0;

    pull_block = 1'b1; pull_req = 1'b1;
    repeat (5) cyc();
    pin("blk_stall", 32'(stall), 32'd1);
    push(32'h0F0F0000);
    p = fifo_pop;
    pin("blk_pop", 32'(p), 32'd1);
    cyc();
    p = stall;
    pin("blk_fetch_stall", 32'(p), 32'd0);
    cyc();
    pull_req = 1'b0;
    pull_block = 1'b0; pull_req = 1'b1;
    #1 p = stall;
    cyc();
    pull_req = 1'b0;
    pin("nb_stall", 32'(p), 32'd0);
    do_out(5'd16, 1'b0, k);
    d = out_data; c = osr_count;
    pin("l16_data", d, 32'h00000F0F);
    pin("l16_count", 32'(c), 32'd16);
    do_out(5'd0, 1'b0, k);
    pin("l32z_data", out_data, 32'd0);
    do_out(5'd5, 1'b0, k);
    pin("sat_count", 32'(osr_count), 32'd32);

    push(32'hCAFEF00D);
    do_pull(1'b1, k, p);
    autopull_en = 1'b1; pull_thresh = 5'd8;
    do_out(5'd8, 1'b1, k);
    d = out_data;
    pin("t8_data", d, 32'h0D);
    out_bits = 5'd4; shift_right = 1'b1; out_req = 1'b1;
    repeat (3) cyc();
    p = stall;
    pin("t8_empty_stall", 32'(p), 32'd1);
    push(32'h11112222);
    wait_done(k, p);
    out_req = 1'b0;
    d = out_data; c = osr_count;
    pin("t8_data2", d, 32'h2);
    pin("t8_count2", 32'(c), 32'd4);
    autopull_en = 1'b0;

    push(32'h89ABCDEF);
    do_pull(1'b1, k, p);
    do_out(5'd12, 1'b0, k);
    pin("l12_data", out_data, 32'h89A);
    do_out(5'd3, 1'b1, k);
    pin("r3_data", out_data, 32'h0);
    do_out(5'd20, 1'b1, k);
    d = out_data; c = osr_count;
    pin("r20_data", d, 32'h000BDE00);
    pin("r20_count", 32'(c), 32'd32);

    push(32'h77777777);
    pull_block = 1'b1; pull_req = 1'b1;
    cyc();
    rst = 1'b1; pull_req = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    pin("frst_count", 32'(osr_count), 32'd32);
    pin("frst_data", out_data, 32'd0);
    pin("frst_empty", 32'(fifo_empty), 32'd1);
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
